// File: rtl/control_sequencer_if.sv
// Bundle between the control sequencer and the DataPath: opcode/memory/stop inputs
// toward the sequencer and every DataPath control strobe plus status back out.
interface control_sequencer_if #(
  parameter int OP_W  = 5,
  parameter int CNT_W = 16
);
  logic [OP_W-1:0]  ir_op;
  logic             mem_ready;
  logic             stop;
  logic             PCout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin, IncPC, Read, Write;
  logic             Gra, Grb, Grc, Rin, Rout, BAout, Cout;
  logic [4:0]       Operator;
  logic [3:0]       step;
  logic             run;
  logic             mem_err;
  logic [CNT_W-1:0] instr_cnt;

  modport master (
    input  ir_op, mem_ready, stop,
    output PCout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin, IncPC, Read, Write,
    output Gra, Grb, Grc, Rin, Rout, BAout, Cout, Operator, step, run, mem_err, instr_cnt
  );

  modport slave (
    output ir_op, mem_ready, stop,
    input  PCout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin, IncPC, Read, Write,
    input  Gra, Grb, Grc, Rin, Rout, BAout, Cout, Operator, step, run, mem_err, instr_cnt
  );
endinterface

// File: rtl/control_sequencer.sv
// Hardwired fetch/decode/execute sequencer for the DataPath: T0..T7 FSM with memory wait
// states, wait timeout, stop-at-boundary request and a retired-instruction counter.
module control_sequencer #(
  parameter int OP_W    = 5,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                clear,
  control_sequencer_if.master bus
);
  typedef enum logic [3:0] {
    S_RST = 4'd0, S_T0 = 4'd1, S_T1 = 4'd2, S_T2 = 4'd3, S_T3 = 4'd4,
    S_T4 = 4'd5, S_T5 = 4'd6, S_T6 = 4'd7, S_T7 = 4'd8, S_HALTED = 4'd15
  } state_t;

  typedef enum logic [2:0] {K_LD, K_LDI, K_ST, K_REG, K_IMM, K_NOP, K_HALT} kind_t;

  function automatic kind_t decode(input logic [OP_W-1:0] op);
    if (op == OP_W'(0))                            return K_LD;
    else if (op == OP_W'(1))                       return K_LDI;
    else if (op == OP_W'(2))                       return K_ST;
    else if (op >= OP_W'(3) && op <= OP_W'(11))    return K_REG;
    else if (op >= OP_W'(12) && op <= OP_W'(14))   return K_IMM;
    else if (op == OP_W'(27))                      return K_HALT;
    else                                           return K_NOP;
  endfunction

  function automatic logic [4:0] imm_operator(input logic [OP_W-1:0] op);
    if (op == OP_W'(12))      return 5'd3;
    else if (op == OP_W'(13)) return 5'd5;
    else                      return 5'd6;
  endfunction

  state_t           state_reg, state_next;
  logic [OP_W-1:0]  op_reg;
  logic [7:0]       wait_cnt_reg, wait_cnt_next;
  logic             stop_reg;
  logic             mem_err_reg;
  logic [CNT_W-1:0] instr_cnt_reg;
  logic             is_wait, retire, timeout;
  kind_t            cur_kind;

  // In T3 the opcode is only now valid on ir_op; afterwards the latched copy is used.
  assign cur_kind = (state_reg == S_T3) ? decode(bus.ir_op) : decode(op_reg);

  always_ff @(posedge clk) begin
    if (clear) begin
      state_reg     <= S_RST;
      op_reg        <= '0;
      wait_cnt_reg  <= '0;
      stop_reg      <= 1'b0;
      mem_err_reg   <= 1'b0;
      instr_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      if (state_reg == S_T3)
        op_reg <= bus.ir_op;
      if (bus.stop && state_reg != S_RST)
        stop_reg <= 1'b1;
      if (timeout)
        mem_err_reg <= 1'b1;
      if (retire)
        instr_cnt_reg <= instr_cnt_reg + CNT_W'(1);
    end
  end

  always_comb begin
    state_next = state_reg;
    is_wait    = 1'b0;
    retire     = 1'b0;
    timeout    = 1'b0;
    case (state_reg)
      S_RST: state_next = S_T0;
      S_T0:  state_next = S_T1;
      S_T1: begin
        is_wait = 1'b1;
        if (bus.mem_ready) state_next = S_T2;
      end
      S_T2: state_next = S_T3;
      S_T3: begin
        if (cur_kind == K_NOP || cur_kind == K_HALT) retire = 1'b1;
        else                                         state_next = S_T4;
      end
      S_T4: state_next = S_T5;
      S_T5: begin
        if (cur_kind == K_LD || cur_kind == K_ST) state_next = S_T6;
        else                                      retire = 1'b1;
      end
      S_T6: begin
        if (cur_kind == K_LD) begin
          is_wait = 1'b1;
          if (bus.mem_ready) state_next = S_T7;
        end else begin
          state_next = S_T7;
        end
      end
      S_T7: begin
        if (cur_kind == K_ST) begin
          is_wait = 1'b1;
          if (bus.mem_ready) retire = 1'b1;
        end else begin
          retire = 1'b1;
        end
      end
      S_HALTED: state_next = S_HALTED;
      default:  state_next = S_RST;
    endcase
    if (is_wait && !bus.mem_ready && wait_cnt_reg == 8'(TIMEOUT - 1)) begin
      timeout    = 1'b1;
      state_next = S_HALTED;
    end
    // A pending stop is honoured even if it arrives in the final step itself.
    if (retire)
      state_next = (cur_kind == K_HALT || stop_reg || bus.stop) ? S_HALTED : S_T0;
    wait_cnt_next = (is_wait && !bus.mem_ready && !timeout) ? wait_cnt_reg + 8'd1 : 8'd0;
  end

  always_comb begin
    {bus.PCout, bus.Zlowout, bus.MDRout, bus.MARin, bus.Zin, bus.PCin, bus.MDRin} = '0;
    {bus.IRin, bus.Yin, bus.IncPC, bus.Read, bus.Write}                           = '0;
    {bus.Gra, bus.Grb, bus.Grc, bus.Rin, bus.Rout, bus.BAout, bus.Cout}           = '0;
    bus.Operator = 5'd0;
    case (state_reg)
      S_T0: {bus.PCout, bus.MARin, bus.IncPC, bus.Zin} = 4'b1111;
      S_T1: {bus.Zlowout, bus.PCin, bus.Read, bus.MDRin} = 4'b1111;
      S_T2: {bus.MDRout, bus.IRin} = 2'b11;
      S_T3: begin
        if (cur_kind == K_LD || cur_kind == K_LDI || cur_kind == K_ST)
          {bus.Grb, bus.BAout, bus.Yin} = 3'b111;
        else if (cur_kind == K_REG || cur_kind == K_IMM)
          {bus.Grb, bus.Rout, bus.Yin} = 3'b111;
      end
      S_T4: begin
        if (cur_kind == K_REG) begin
          {bus.Grc, bus.Rout, bus.Zin} = 3'b111;
          bus.Operator = 5'(op_reg);
        end else if (cur_kind == K_IMM) begin
          {bus.Cout, bus.Zin} = 2'b11;
          bus.Operator = imm_operator(op_reg);
        end else begin
          {bus.Cout, bus.Zin} = 2'b11;
          bus.Operator = 5'd3;
        end
      end
      S_T5: begin
        if (cur_kind == K_LD || cur_kind == K_ST) {bus.Zlowout, bus.MARin} = 2'b11;
        else                                      {bus.Zlowout, bus.Gra, bus.Rin} = 3'b111;
      end
      S_T6: begin
        if (cur_kind == K_LD) {bus.Read, bus.MDRin} = 2'b11;
        else                  {bus.Gra, bus.Rout, bus.MDRin} = 3'b111;
      end
      S_T7: begin
        if (cur_kind == K_LD) {bus.MDRout, bus.Gra, bus.Rin} = 3'b111;
        else                  bus.Write = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.step      = state_reg;
  assign bus.run       = (state_reg != S_RST) && (state_reg != S_HALTED);
  assign bus.mem_err   = mem_err_reg;
  assign bus.instr_cnt = instr_cnt_reg;
endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: each instruction is expanded into an expected per-cycle trace
// (step, strobes, Operator, memory handshake) and compared cycle by cycle.
module tb_control_sequencer;
  localparam int OP_W = 5, CNT_W = 8, TIMEOUT = 15;
  localparam int K_LD = 0, K_LDI = 1, K_ST = 2, K_REG = 3, K_IMM = 4, K_NOP = 5, K_HALT = 6;

  localparam logic [18:0] M_PCOUT = 19'b1 << 0,  M_ZLOWOUT = 19'b1 << 1,  M_MDROUT = 19'b1 << 2;
  localparam logic [18:0] M_MARIN = 19'b1 << 3,  M_ZIN     = 19'b1 << 4,  M_PCIN   = 19'b1 << 5;
  localparam logic [18:0] M_MDRIN = 19'b1 << 6,  M_IRIN    = 19'b1 << 7,  M_YIN    = 19'b1 << 8;
  localparam logic [18:0] M_INCPC = 19'b1 << 9,  M_READ    = 19'b1 << 10, M_WRITE  = 19'b1 << 11;
  localparam logic [18:0] M_GRA   = 19'b1 << 12, M_GRB     = 19'b1 << 13, M_GRC    = 19'b1 << 14;
  localparam logic [18:0] M_RIN   = 19'b1 << 15, M_ROUT    = 19'b1 << 16, M_BAOUT  = 19'b1 << 17;
  localparam logic [18:0] M_COUT  = 19'b1 << 18;

  typedef struct {
    logic [3:0]  st;
    logic [18:0] m;
    logic [4:0]  op;
    logic        mr;
    logic        t3;
  } ent_t;

  logic clk = 1'b0;
  logic clear = 1'b1;
  always #5 clk = ~clk;

  control_sequencer_if #(.OP_W(OP_W), .CNT_W(CNT_W)) bus();
  control_sequencer #(.OP_W(OP_W), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .clear(clear), .bus(bus)
  );

  logic [18:0] obs_mask;
  assign obs_mask = {bus.Cout, bus.BAout, bus.Rout, bus.Rin, bus.Grc, bus.Grb, bus.Gra,
                     bus.Write, bus.Read, bus.IncPC, bus.Yin, bus.IRin, bus.MDRin, bus.PCin,
                     bus.Zin, bus.MARin, bus.MDRout, bus.Zlowout, bus.PCout};

  int checks, errors;
  ent_t tr[$];
  bit timed_out, halted_m, err_m;
  logic [CNT_W-1:0] cnt_m;

  function automatic int kind_of(input logic [4:0] op);
    if (op == 0) return K_LD;
    if (op == 1) return K_LDI;
    if (op == 2) return K_ST;
    if (op >= 3 && op <= 11) return K_REG;
    if (op >= 12 && op <= 14) return K_IMM;
    if (op == 27) return K_HALT;
    return K_NOP;
  endfunction

  task automatic reset_model();
    cnt_m = '0; err_m = 0; halted_m = 0;
  endtask

  task automatic check(input string tag, input logic [3:0] st, input logic [18:0] m,
                       input logic [4:0] op, input logic rn);
    checks++;
    assert (bus.step === st && obs_mask === m && bus.Operator === op && bus.run === rn &&
            bus.mem_err === err_m && bus.instr_cnt === cnt_m)
    else begin
      errors++;
      $error("FAIL %s: got step=%0d strobes=%h op=%h run=%b err=%b cnt=%0d, want step=%0d strobes=%h op=%h run=%b err=%b cnt=%0d",
             tag, bus.step, obs_mask, bus.Operator, bus.run, bus.mem_err, bus.instr_cnt,
             st, m, op, rn, err_m, cnt_m);
    end
  endtask

  task automatic push_e(input logic [3:0] st, input logic [18:0] m, input logic [4:0] op,
                        input logic mr, input logic t3);
    ent_t e;
    e.st = st; e.m = m; e.op = op; e.mr = mr; e.t3 = t3;
    tr.push_back(e);
  endtask

  task automatic push_wait(input logic [3:0] st, input logic [18:0] m, input int w);
    for (int k = 0; k < w && k < TIMEOUT; k++) push_e(st, m, 5'd0, 1'b0, 1'b0);
    if (w >= TIMEOUT) timed_out = 1;
    else push_e(st, m, 5'd0, 1'b1, 1'b0);
  endtask

  task automatic build_trace(input logic [4:0] op, input int w1, input int wm);
    int k;
    tr.delete();
    timed_out = 0;
    k = kind_of(op);
    push_e(4'd1, M_PCOUT | M_MARIN | M_INCPC | M_ZIN, 5'd0, 1'($urandom_range(0, 1)), 1'b0);
    push_wait(4'd2, M_ZLOWOUT | M_PCIN | M_READ | M_MDRIN, w1);
    if (timed_out) return;
    push_e(4'd3, M_MDROUT | M_IRIN, 5'd0, 1'($urandom_range(0, 1)), 1'b0);
    if (k == K_LD || k == K_LDI || k == K_ST)
      push_e(4'd4, M_GRB | M_BAOUT | M_YIN, 5'd0, 1'($urandom_range(0, 1)), 1'b1);
    else if (k == K_REG || k == K_IMM)
      push_e(4'd4, M_GRB | M_ROUT | M_YIN, 5'd0, 1'($urandom_range(0, 1)), 1'b1);
    else
      push_e(4'd4, 19'd0, 5'd0, 1'($urandom_range(0, 1)), 1'b1);
    if (k == K_NOP || k == K_HALT) return;
    if (k == K_REG)
      push_e(4'd5, M_GRC | M_ROUT | M_ZIN, op, 1'($urandom_range(0, 1)), 1'b0);
    else if (k == K_IMM)
      push_e(4'd5, M_COUT | M_ZIN, (op == 12) ? 5'd3 : (op == 13) ? 5'd5 : 5'd6,
             1'($urandom_range(0, 1)), 1'b0);
    else
      push_e(4'd5, M_COUT | M_ZIN, 5'd3, 1'($urandom_range(0, 1)), 1'b0);
    if (k != K_LD && k != K_ST) begin
      push_e(4'd6, M_ZLOWOUT | M_GRA | M_RIN, 5'd0, 1'($urandom_range(0, 1)), 1'b0);
      return;
    end
    push_e(4'd6, M_ZLOWOUT | M_MARIN, 5'd0, 1'($urandom_range(0, 1)), 1'b0);
    if (k == K_LD) begin
      push_wait(4'd7, M_READ | M_MDRIN, wm);
      if (timed_out) return;
      push_e(4'd8, M_MDROUT | M_GRA | M_RIN, 5'd0, 1'($urandom_range(0, 1)), 1'b0);
    end else begin
      push_e(4'd7, M_GRA | M_ROUT | M_MDRIN, 5'd0, 1'($urandom_range(0, 1)), 1'b0);
      push_wait(4'd8, M_WRITE, wm);
    end
  endtask

  task automatic do_reset(input logic stop_in_rst);
    @(negedge clk);
    clear = 1'b1;
    bus.stop = 1'($urandom_range(0, 1));
    bus.mem_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    clear = 1'b0;
    bus.stop = stop_in_rst;
    #1;
    reset_model();
    check("reset", 4'd0, 19'd0, 5'd0, 1'b0);
  endtask

  // Runs one instruction from T0; stop_idx/clr_idx pulse stop/clear at that trace cycle (-1 = never).
  task automatic exec(input logic [4:0] op, input int w1, input int wm,
                      input int stop_idx, input int clr_idx);
    bit stop_seen;
    stop_seen = 0;
    build_trace(op, w1, wm);
    for (int i = 0; i < tr.size(); i++) begin
      @(negedge clk);
      bus.ir_op     = tr[i].t3 ? op : 5'($urandom);
      bus.mem_ready = tr[i].mr;
      bus.stop      = (i == stop_idx);
      clear         = (i == clr_idx);
      if (i == stop_idx) stop_seen = 1;
      #1;
      check($sformatf("op%0d_cyc%0d", op, i), tr[i].st, tr[i].m, tr[i].op, 1'b1);
      if (i == clr_idx) begin
        reset_model();
        @(negedge clk);
        clear = 1'b0;
        bus.stop = 1'b0;
        #1;
        check("clear_abort", 4'd0, 19'd0, 5'd0, 1'b0);
        return;
      end
    end
    if (timed_out) begin
      err_m = 1; halted_m = 1;
    end else begin
      cnt_m++;
      if (kind_of(op) == K_HALT || stop_seen) halted_m = 1;
    end
    if (halted_m) begin
      repeat (2) begin
        @(negedge clk);
        bus.ir_op = 5'($urandom);
        bus.mem_ready = 1'($urandom_range(0, 1));
        bus.stop = 1'($urandom_range(0, 1));
        #1;
        check($sformatf("halted_after_op%0d", op), 4'd15, 19'd0, 5'd0, 1'b0);
      end
    end
  endtask

  initial begin
    int w1, wm, sidx, cidx;
    logic [4:0] op;
    checks = 0; errors = 0;
    bus.ir_op = '0; bus.mem_ready = 1'b1; bus.stop = 1'b0;
    reset_model();

    do_reset(1'b0);
    exec(5'd0, 0, 0, -1, -1);      // ld
    exec(5'd2, 0, 3, -1, -1);      // st, Write held 4 cycles
    exec(5'd13, 0, 0, -1, -1);     // andi
    exec(5'd4, 0, 0, -1, -1);      // sub
    exec(5'd1, 1, 0, -1, -1);      // ldi with one fetch wait
    exec(5'd12, 0, 0, -1, -1);     // addi
    exec(5'd14, 0, 0, -1, -1);     // ori
    exec(5'd11, 0, 0, -1, -1);     // last ALU-reg opcode
    exec(5'd26, 0, 0, -1, -1);     // nop
    exec(5'd31, 0, 0, -1, -1);     // illegal runs as nop
    exec(5'd0, 14, 14, -1, -1);    // longest waits that still succeed
    exec(5'd3, 0, 0, 4, -1);       // stop in T4 -> completes then halts
    do_reset(1'b1);                // stop during RST must be ignored
    exec(5'd14, 0, 0, -1, -1);
    exec(5'd27, 0, 0, -1, -1);     // halt
    do_reset(1'b0);
    exec(5'd26, 15, 0, -1, -1);    // fetch timeout
    do_reset(1'b0);
    exec(5'd2, 0, 15, -1, -1);     // store timeout
    do_reset(1'b0);
    exec(5'd0, 2, 0, -1, 2);       // clear mid-wait
    exec(5'd26, 0, 0, 3, -1);      // stop in the final step itself
    do_reset(1'b0);
    repeat (260) exec(5'd26, 0, 0, -1, -1);  // instr_cnt wraps past 2^CNT_W

    for (int n = 0; n < 400; n++) begin
      op = 5'($urandom_range(0, 31));
      w1 = ($urandom_range(0, 9) == 0) ? $urandom_range(3, 14) : $urandom_range(0, 2);
      wm = ($urandom_range(0, 9) == 0) ? $urandom_range(3, 14) : $urandom_range(0, 2);
      sidx = ($urandom_range(0, 19) == 0) ? $urandom_range(0, 8) : -1;
      cidx = ($urandom_range(0, 29) == 0) ? $urandom_range(0, 5) : -1;
      exec(op, w1, wm, sidx, cidx);
      if (halted_m) do_reset(1'b0);
    end

    @(negedge clk);
    bus.stop = 1'b0;
    #1;
    check("final_t0", 4'd1, M_PCOUT | M_MARIN | M_INCPC | M_ZIN, 5'd0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
